// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- general-purpose register file with RAW-hazard scoreboard
//
// Purpose:
//   Parametrised LEGv8 register file. It has N_RD registered read ports and
//   one write port. ZERO_REG is hard-wired to zero. A write at the same edge
//   as a read of the same register is forwarded to that read. A per-register
//   busy scoreboard is kept for decode: a claim at issue marks the destination
//   busy, and the writeback write clears it. A flush clears every busy bit.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    register address width
//   NREGS     number of implemented registers (<= 2**ADDR_W)
//   N_RD      number of read ports
//   ZERO_REG  index of the constant-zero register (XZR)
//
// Ports:
//   clock       in   system clock, all state updates on posedge
//   reset_n     in   asynchronous active-low reset
//   rd_addr     in   N_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data     out  N_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy     out  N_RD         registered busy flag of the addressed register
//   wr_en       in   write enable
//   wr_addr     in   ADDR_W       write address
//   wr_data     in   DATA_W       write data
//   claim_en    in   mark claim_addr as pending (issued destination)
//   claim_addr  in   ADDR_W       register to claim
//   flush       in   clear every busy bit (data untouched)
//   busy_cnt    out  ADDR_W+1     number of registers currently busy
//
// Build option:
//   REGFILE_INIT_INDEX_EN  when defined, reset loads register i with the
//                          value i (ZERO_REG stays 0). This is for bring-up
//                          programs that expect preset operands. When it is
//                          undefined, reset clears every register.
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 32,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    // Register count and zero index at address width. This avoids mixed-width
    // compares against the int parameters.
    localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

    // An address names a real, writable/claimable register only if it is
    // in range and is not the zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != ZERO_A) && ({1'b0, a} < NREGS_W);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]        r_regs [NREGS];
    logic [NREGS-1:0]         r_busy;
    logic [ADDR_W:0]          r_busy_cnt;
    logic [N_RD*DATA_W-1:0]   r_rd_data;
    logic [N_RD-1:0]          r_rd_busy;

    // -------------------------------------------------------------------------
    // Combinational next-state
    // -------------------------------------------------------------------------
    logic                     w_wr_ok;
    logic                     w_claim_ok;
    logic [NREGS-1:0]         w_wr_hit;
    logic [NREGS-1:0]         w_claim_hit;
    logic [NREGS-1:0]         w_busy_nxt;
    logic                     w_cnt_inc;
    logic                     w_cnt_dec;
    logic [ADDR_W:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]        w_ra [N_RD];
    logic [N_RD-1:0]          w_rd_ok;
    logic [N_RD*DATA_W-1:0]   w_rd_data_nxt;
    logic [N_RD-1:0]          w_rd_busy_nxt;

    assign w_wr_ok    = wr_en    && addr_ok(wr_addr);
    assign w_claim_ok = claim_en && addr_ok(claim_addr);

    // Split the packed read-address bus into per-port addresses.
    for (genvar k = 0; k < N_RD; k++) begin : g_ra
        assign w_ra[k]    = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_rd_ok[k] = addr_ok(w_ra[k]);
    end

    // One-hot write and claim decode. Dropped targets (zero register and
    // out-of-range addresses) decode to all zeros.
    always_comb begin
        w_wr_hit    = '0;
        w_claim_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_wr_hit[i]    = w_wr_ok    && (wr_addr    == ADDR_W'(i));
            w_claim_hit[i] = w_claim_ok && (claim_addr == ADDR_W'(i));
        end
    end

    // Busy-bit update in priority order: flush, then claim, then write
    // clears, then hold. A claim beats a same-register write because the
    // newly issued producer supersedes the one that is writing back.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (flush) begin
                w_busy_nxt[i] = 1'b0;
            end else if (w_claim_hit[i]) begin
                w_busy_nxt[i] = 1'b1;
            end else if (w_wr_hit[i]) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
    end

    // Incremental population count. A claim of an already-busy register
    // does not count again. A write clears a busy register only when the
    // same register is not being claimed in the same cycle.
    always_comb begin
        w_cnt_inc = w_claim_ok && ((w_claim_hit & r_busy) == '0);
        w_cnt_dec = w_wr_ok && ((w_wr_hit & r_busy) != '0)
                            && ((w_wr_hit & w_claim_hit) == '0);
        if (flush) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_busy_cnt + {{ADDR_W{1'b0}}, w_cnt_inc}
                                   - {{ADDR_W{1'b0}}, w_cnt_dec};
        end
    end

    // Read-port mux with write forwarding. Data and busy both show the state
    // after the edge. The zero register and out-of-range addresses read as 0
    // and not busy.
    always_comb begin
        w_rd_data_nxt = '0;
        w_rd_busy_nxt = '0;
        for (int k = 0; k < N_RD; k++) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_rd_ok[k] && (w_ra[k] == ADDR_W'(i))) begin
                    w_rd_data_nxt[k*DATA_W +: DATA_W] = w_wr_hit[i] ? wr_data : r_regs[i];
                    w_rd_busy_nxt[k]                  = w_busy_nxt[i];
                end else begin
                    w_rd_data_nxt[k*DATA_W +: DATA_W] = w_rd_data_nxt[k*DATA_W +: DATA_W];
                    w_rd_busy_nxt[k]                  = w_rd_busy_nxt[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------

    // Register array storage. A write always lands, whatever the busy state or flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
`ifdef REGFILE_INIT_INDEX_EN
                r_regs[i] <= (i == ZERO_REG) ? {DATA_W{1'b0}} : DATA_W'(i);
`else
                r_regs[i] <= {DATA_W{1'b0}};
`endif
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= wr_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Scoreboard busy bits and their running count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    // Registered read-port outputs. Reset clears them immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            r_rd_data <= w_rd_data_nxt;
            r_rd_busy <= w_rd_busy_nxt;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_busy  = r_rd_busy;
    assign busy_cnt = r_busy_cnt;

endmodule
